fir_mac_mch: RTL and testbench

- Generic-tap, multi-channel low-pass FIR built around one time-shared multiplier (one MAC per clock).
- Each channel keeps its own delay line. All channels share one runtime-loadable coefficient set, so the same block serves the DDC-output LPF and other decimation chains.
- Output is rounded (round-half-up), shifted and saturated to a configurable width.
- valid/ready handshake on both input and output; coefficient reloads are double-buffered so they never corrupt an output in flight.

---
 rtl/fir_mac_pkg.sv | 49 ++++
 rtl/fir_coef_bank.sv | 64 ++++++
 rtl/fir_mac_mch.sv | 161 ++++++++++++++++
 tb/tb_fir_mac_mch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_pkg.sv
// Shared types and arithmetic helpers for the time-shared multi-channel FIR (fir_mac_mch).
// Holds the FSM encoding, the width helpers and the output round/saturate function.
package fir_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Working width of round_sat; every accumulator is sign-extended to this first.
    localparam int MAXW = 128;

    function automatic int acc_width(input int wi, input int wc, input int ntaps);
        return wi + wc + $clog2(ntaps);
    endfunction

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Round half up, arithmetic shift right, then clamp to a signed wo-bit range.
    function automatic logic signed [MAXW-1:0] round_sat(
        input logic signed [MAXW-1:0] acc,
        input int                     shift,
        input int                     wo
    );
        logic signed [MAXW-1:0] r;
        logic signed [MAXW-1:0] maxv;
        logic signed [MAXW-1:0] minv;
        if (shift > 0) begin
            r = acc + (128'sd1 <<< (shift - 1));
        end else begin
            r = acc;
        end
        r    = r >>> shift;
        maxv = (128'sd1 <<< (wo - 1)) - 128'sd1;
        minv = -(128'sd1 <<< (wo - 1));
        if (r > maxv) begin
            r = maxv;
        end else if (r < minv) begin
            r = minv;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow bank written at any time, copied to the
// active bank only while the filter is idle so an output in flight sees one set.
module fir_coef_bank
    import fir_mac_pkg::*;
#(
    parameter int NTAPS  = 23,
    parameter int WCOEFF = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coef_wr,
    input  logic [$clog2(NTAPS)-1:0]        coef_addr,
    input  logic signed [WCOEFF-1:0]        coef_data,
    input  logic                            coef_commit,
    input  logic                            idle,
    input  logic [$clog2(NTAPS)-1:0]        rd_idx,
    output logic signed [WCOEFF-1:0]        rd_coef,
    output logic                            coef_pend
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW:0] NT_W = (AW+1)'(NTAPS);

    logic signed [WCOEFF-1:0] shadow_r [NTAPS];
    logic signed [WCOEFF-1:0] active_r [NTAPS];
    logic                     pend_r;
    logic                     addr_ok_s;
    logic                     apply_s;

    // A commit seen while idle applies on the same edge, so a sample accepted then uses it.
    always_comb begin
        addr_ok_s = ({1'b0, coef_addr} < NT_W);
        apply_s   = idle && (pend_r || coef_commit);
    end

    // Shadow writes, shadow-to-active copy and pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_r[k] <= {WCOEFF{1'b0}};
                active_r[k] <= {WCOEFF{1'b0}};
            end
            pend_r <= 1'b0;
        end else begin
            if (coef_wr && addr_ok_s) begin
                shadow_r[coef_addr] <= coef_data;
            end
            if (apply_s) begin
                for (int k = 0; k < NTAPS; k++) begin
                    active_r[k] <= shadow_r[k];
                end
                pend_r <= 1'b0;
            end else if (coef_commit) begin
                pend_r <= 1'b1;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign rd_coef   = active_r[rd_idx];
    assign coef_pend = pend_r;

endmodule

// File: rtl/fir_mac_mch.sv
// Multi-channel FIR with one shared multiplier (one MAC per clock) and per-channel delay lines.
// Define FIR_SYM_EN for even-symmetric coefficients with pre-addition (half the MAC cycles).
module fir_mac_mch
    import fir_mac_pkg::*;
#(
    parameter int NTAPS  = 23,
    parameter int NCH    = 2,
    parameter int WI     = 16,
    parameter int WCOEFF = 16,
    parameter int WO     = 16,
    parameter int SHIFT  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WI-1:0]          d_in,
    input  logic [ch_width(NCH)-1:0]      d_in_ch,
    input  logic                          d_in_val,
    output logic                          d_in_rdy,
    output logic signed [WO-1:0]          d_out,
    output logic [ch_width(NCH)-1:0]      d_out_ch,
    output logic                          d_out_val,
    input  logic                          d_out_rdy,
    input  logic                          coef_wr,
    input  logic [$clog2(NTAPS)-1:0]      coef_addr,
    input  logic signed [WCOEFF-1:0]      coef_data,
    input  logic                          coef_commit,
    output logic                          coef_pend
);

    localparam int CW   = ch_width(NCH);
    localparam int IW   = $clog2(NTAPS);
    localparam int ACCW = acc_width(WI, WCOEFF, NTAPS);
`ifdef FIR_SYM_EN
    localparam int MACN = (NTAPS + 1) / 2;
`else
    localparam int MACN = NTAPS;
`endif
    localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);
    localparam logic [IW-1:0] LAST_IDX = IW'(MACN - 1);

    fir_state_t               state_r;
    logic                     in_rdy_r;
    logic signed [WO-1:0]     d_out_r;
    logic [CW-1:0]            ch_out_r;
    logic                     out_val_r;
    logic signed [ACCW-1:0]   acc_r;
    logic [IW-1:0]            idx_r;
    logic [CW-1:0]            ch_r;
    logic signed [WI-1:0]     dly_r [NCH][NTAPS];

    logic signed [WCOEFF-1:0] coef_s;
    logic signed [WI-1:0]     tap_a_s;
    logic signed [WI:0]       pre_s;
    logic signed [ACCW-1:0]   prod_s;
    logic                     ch_ok_s;
`ifdef FIR_SYM_EN
    logic [IW-1:0]            ridx_s;
`endif

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .WCOEFF (WCOEFF)
    ) u_coef (
        .clk         (clk),
        .rst         (rst),
        .coef_wr     (coef_wr),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .idle        (state_r == IDLE),
        .rd_idx      (idx_r),
        .rd_coef     (coef_s),
        .coef_pend   (coef_pend)
    );

    // Tap product for the current MAC index; symmetric mode folds mirrored taps first.
    always_comb begin
        ch_ok_s = ({1'b0, d_in_ch} < NCH_W);
        tap_a_s = dly_r[ch_r][idx_r];
`ifdef FIR_SYM_EN
        ridx_s = IW'(NTAPS - 1) - idx_r;
        if (ridx_s == idx_r) begin
            pre_s = (WI+1)'(tap_a_s);
        end else begin
            pre_s = (WI+1)'(tap_a_s) + (WI+1)'(dly_r[ch_r][ridx_s]);
        end
`else
        pre_s = (WI+1)'(tap_a_s);
`endif
        prod_s = ACCW'(pre_s) * ACCW'(coef_s);
    end

    // Control FSM, delay lines, accumulator and registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            in_rdy_r  <= 1'b1;
            d_out_r   <= {WO{1'b0}};
            ch_out_r  <= {CW{1'b0}};
            out_val_r <= 1'b0;
            acc_r     <= {ACCW{1'b0}};
            idx_r     <= {IW{1'b0}};
            ch_r      <= {CW{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAPS; k++) begin
                    dly_r[c][k] <= {WI{1'b0}};
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_in_val && in_rdy_r && ch_ok_s) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (CW'(c) == d_in_ch) begin
                                dly_r[c][0] <= d_in;
                                for (int k = 1; k < NTAPS; k++) begin
                                    dly_r[c][k] <= dly_r[c][k-1];
                                end
                            end
                        end
                        ch_r     <= d_in_ch;
                        acc_r    <= {ACCW{1'b0}};
                        idx_r    <= {IW{1'b0}};
                        in_rdy_r <= 1'b0;
                        state_r  <= MAC;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + prod_s;
                    idx_r <= idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        state_r <= OUT;
                    end
                end
                OUT: begin
                    // First OUT cycle captures the result; later cycles wait for the handshake.
                    if (!out_val_r) begin
                        d_out_r   <= WO'(round_sat(MAXW'(acc_r), SHIFT, WO));
                        ch_out_r  <= ch_r;
                        out_val_r <= 1'b1;
                    end else if (d_out_rdy) begin
                        out_val_r <= 1'b0;
                        in_rdy_r  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_rdy_r  <= 1'b1;
                    out_val_r <= 1'b0;
                end
            endcase
        end
    end

    assign d_in_rdy  = in_rdy_r;
    assign d_out     = d_out_r;
    assign d_out_ch  = ch_out_r;
    assign d_out_val = out_val_r;

endmodule

// File: tb/tb_fir_mac_mch.sv
// Self-checking bench for fir_mac_mch (NTAPS=4, NCH=2) against a sum-of-products reference model.
module tb_fir_mac_mch;

    localparam int NTAPS  = 4;
    localparam int NCH    = 2;
    localparam int WI     = 16;
    localparam int WCOEFF = 16;
    localparam int WO     = 16;
    localparam int SHIFT  = 15;
`ifdef FIR_SYM_EN
    localparam int MACN = (NTAPS + 1) / 2;
`else
    localparam int MACN = NTAPS;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic signed [WI-1:0]     d_in = '0;
    logic [0:0]               d_in_ch = '0;
    logic                     d_in_val = 1'b0;
    logic                     d_in_rdy;
    logic signed [WO-1:0]     d_out;
    logic [0:0]               d_out_ch;
    logic                     d_out_val;
    logic                     d_out_rdy = 1'b1;
    logic                     coef_wr = 1'b0;
    logic [1:0]               coef_addr = '0;
    logic signed [WCOEFF-1:0] coef_data = '0;
    logic                     coef_commit = 1'b0;
    logic                     coef_pend;

    int errors = 0;
    int checks = 0;

    int hist   [NCH][NTAPS];
    int act_m  [NTAPS];
    int shad_m [NTAPS];
    logic signed [WO-1:0] exp_out;
    logic [0:0]           exp_ch;

    always #5 clk = ~clk;

    fir_mac_mch #(
        .NTAPS(NTAPS), .NCH(NCH), .WI(WI), .WCOEFF(WCOEFF), .WO(WO), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .d_in(d_in), .d_in_ch(d_in_ch), .d_in_val(d_in_val), .d_in_rdy(d_in_rdy),
        .d_out(d_out), .d_out_ch(d_out_ch), .d_out_val(d_out_val), .d_out_rdy(d_out_rdy),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .coef_pend(coef_pend)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int coef_eff(input int k);
`ifdef FIR_SYM_EN
        return act_m[(k < NTAPS - 1 - k) ? k : NTAPS - 1 - k];
`else
        return act_m[k];
`endif
    endfunction

    // Reference: full-precision dot product, round half up, floor shift, clamp.
    function automatic int model_out(input int ch);
        longint acc = 0;
        longint lim = longint'(1) << (WO - 1);
        for (int k = 0; k < NTAPS; k++) acc += longint'(hist[ch][k]) * longint'(coef_eff(k));
        if (SHIFT > 0) acc += longint'(1) << (SHIFT - 1);
        acc = acc >>> SHIFT;
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim) acc = -lim;
        return int'(acc);
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) hist[c][k] = 0;
        for (int k = 0; k < NTAPS; k++) begin
            act_m[k]  = 0;
            shad_m[k] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        coef_commit = 1'b0;
        d_in_val = 1'b0;
        d_out_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        coef_wr = 1'b1;
        coef_addr = a[1:0];
        coef_data = v[WCOEFF-1:0];
        @(negedge clk);
        coef_wr = 1'b0;
        shad_m[a] = v;
    endtask

    task automatic commit_idle();
        @(negedge clk);
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        for (int k = 0; k < NTAPS; k++) act_m[k] = shad_m[k];
        check("pend_after_idle_commit", coef_pend, 1'b0);
    endtask

    task automatic accept(input int ch, input int x, input bit mid_commit);
        int w = 0;
        @(negedge clk);
        while (d_in_rdy !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_rdy_wait", d_in_rdy, 1'b1);
        d_in = x[WI-1:0];
        d_in_ch = ch[0:0];
        d_in_val = 1'b1;
        @(posedge clk);
        for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = x;
        exp_out = WO'(model_out(ch));
        exp_ch = ch[0:0];
        @(negedge clk);
        d_in_val = 1'b0;
        coef_commit = mid_commit;
    endtask

    task automatic collect(input int hold);
        int lat = 0;
        while (d_out_val !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            coef_commit = 1'b0;
        end
        check("latency", lat, MACN + 1);
        check("d_out", d_out, exp_out);
        check("d_out_ch", d_out_ch, exp_ch);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_val", d_out_val, 1'b1);
            check("hold_data", d_out, exp_out);
            check("hold_ch", d_out_ch, exp_ch);
            check("hold_in_rdy", d_in_rdy, 1'b0);
        end
        d_out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("val_after_hs", d_out_val, 1'b0);
        check("in_rdy_after_hs", d_in_rdy, 1'b1);
    endtask

    task automatic run_one(input int ch, input int x, input int hold);
        if (hold > 0) d_out_rdy = 1'b0;
        accept(ch, x, 1'b0);
        collect(hold);
    endtask

    function automatic int rnd_coef();
        return int'($urandom_range(40000)) - 20000;
    endfunction

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_in_rdy", d_in_rdy, 1'b1);
        check("rst_out_val", d_out_val, 1'b0);
        check("rst_d_out", d_out, 16'sd0);
        check("rst_d_out_ch", d_out_ch, 1'b0);
        check("rst_pend", coef_pend, 1'b0);
        rst = 1'b0;

        // Step response
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16384);
        commit_idle();
        for (int i = 0; i < 5; i++) run_one(0, 1000, 0);

        // Saturation both rails
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 32767);
        commit_idle();
        for (int i = 0; i < 3; i++) run_one(0, 32767, 0);
        for (int i = 0; i < 5; i++) run_one(0, -32768, 0);

        // Round half up
        do_reset();
        write_coef(0, 16384);
        commit_idle();
        run_one(0, 1, 0);
        run_one(0, -1, 0);

        // Channel isolation: impulse on ch1, zeros on ch0
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, rnd_coef());
        commit_idle();
        for (int i = 0; i < 5; i++) begin
            run_one(1, (i == 0) ? 32767 : 0, 0);
            run_one(0, 0, 0);
        end

        // Back-pressure
        run_one(1, 777, 10);
        run_one(1, -555, 0);

        // Commit during MAC: current output keeps the old set
        for (int k = 0; k < NTAPS; k++) write_coef(k, rnd_coef());
        accept(0, 12345, 1'b1);
        collect(0);
        check("pend_held_until_idle", coef_pend, 1'b1);
        @(negedge clk);
        check("pend_cleared_in_idle", coef_pend, 1'b0);
        for (int k = 0; k < NTAPS; k++) act_m[k] = shad_m[k];
        run_one(0, -4321, 0);

        // Randomized traffic with occasional coefficient reloads
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7) begin
                for (int k = 0; k < NTAPS; k++) write_coef(k, rnd_coef());
                commit_idle();
            end
            run_one(int'($urandom_range(1)), int'($urandom_range(65535)) - 32768,
                    ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        // Reset during MAC
        accept(1, 9999, 1'b1);
        @(posedge clk);
        @(negedge clk);
        coef_commit = 1'b0;
        check("pend_before_rst", coef_pend, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_val", d_out_val, 1'b0);
        check("rst_mid_in_rdy", d_in_rdy, 1'b1);
        check("rst_mid_pend", coef_pend, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16384);
        commit_idle();
        run_one(1, 2000, 0);
        run_one(1, 2000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
